// File: rtl/gpio_pkg.sv
// Shared constants for the memory-mapped LED/switch GPIO peripheral.
package gpio_pkg;

  localparam int unsigned NUM_LEDS = 4;

  localparam logic [1:0] OFF_LED_DATA     = 2'd0;
  localparam logic [1:0] OFF_BLINK_MASK   = 2'd1;
  localparam logic [1:0] OFF_STATUS       = 2'd2;
  localparam logic [1:0] OFF_BLINK_PERIOD = 2'd3;

  localparam int unsigned ST_LEVEL = 0;
  localparam int unsigned ST_RISE  = 1;

  // Assemble the STATUS read word from the debounced level and sticky flag.
  function automatic logic [31:0] status_word(input logic level, input logic rise);
    logic [31:0] w;
    w           = '0;
    w[ST_LEVEL] = level;
    w[ST_RISE]  = rise;
    return w;
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus stability counter; rise_pulse marks the edge
// on which the debounced level goes 0->1.
module switch_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = level_d & ~level_q;

endmodule

// File: rtl/mmio_led_switch_gpio.sv
// GPIO peripheral on the core data-memory port: LED register with blink,
// debounced switch status and a sticky write-1-to-clear rise flag.
module mmio_led_switch_gpio
  import gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0000,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic [31:0] BLINK_DEFAULT   = 32'd8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                hit,
  input  logic                SWITCH_in,
  output logic [NUM_LEDS-1:0] LEDs_out,
  output logic                switch_irq
);

  logic                win_c, wr_c;
  logic [1:0]          off_c;
  logic                level_c, rise_c;
  logic                addr_lsb_unused;

  logic [NUM_LEDS-1:0] led_q, led_d;
  logic [NUM_LEDS-1:0] mask_q, mask_d;
  logic [31:0]         period_q, period_d;
  logic [31:0]         presc_q, presc_d;
  logic                phase_q, phase_d;
  logic                sticky_q, sticky_d;

  assign win_c           = (addr[31:4] == BASE_ADDR[31:4]);
  assign off_c           = addr[3:2];
  assign wr_c            = mem_write & win_c;
  assign addr_lsb_unused = ^addr[1:0];

  switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
    .clock      (clock),
    .reset      (reset),
    .raw_in     (SWITCH_in),
    .level_out  (level_c),
    .rise_pulse (rise_c)
  );

  // Register writes, blink prescaler and sticky flag next-state.
  always_comb begin
    led_d    = led_q;
    mask_d   = mask_q;
    period_d = period_q;
    presc_d  = presc_q;
    phase_d  = phase_q;
    sticky_d = sticky_q;

    if (wr_c && off_c == OFF_LED_DATA)   led_d  = wdata[NUM_LEDS-1:0];
    if (wr_c && off_c == OFF_BLINK_MASK) mask_d = wdata[NUM_LEDS-1:0];

    if (wr_c && off_c == OFF_BLINK_PERIOD) begin
      period_d = wdata;
      presc_d  = '0;
    end else if (period_q == '0) begin
      presc_d = '0;
    end else if (presc_q == period_q - 32'd1) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end else begin
      presc_d = presc_q + 32'd1;
    end

    // A new rise on the same edge as a clear keeps the flag set.
    if (rise_c) begin
      sticky_d = 1'b1;
    end else if (wr_c && off_c == OFF_STATUS && wdata[ST_RISE]) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      led_q    <= '0;
      mask_q   <= '0;
      period_q <= BLINK_DEFAULT;
      presc_q  <= '0;
      phase_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      led_q    <= led_d;
      mask_q   <= mask_d;
      period_q <= period_d;
      presc_q  <= presc_d;
      phase_q  <= phase_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (mem_read && win_c) begin
      case (off_c)
        OFF_LED_DATA:   rdata = 32'(led_q);
        OFF_BLINK_MASK: rdata = 32'(mask_q);
        OFF_STATUS:     rdata = status_word(level_c, sticky_q);
        default:        rdata = period_q;
      endcase
    end
  end

  assign hit        = win_c & (mem_read | mem_write);
  assign LEDs_out   = led_q ^ (mask_q & {NUM_LEDS{phase_q}});
  assign switch_irq = sticky_q;

endmodule

// File: tb/tb_mmio_led_switch_gpio.sv
// Directed and randomized checks of the GPIO peripheral against a
// behavioural model driven by the register-map and timing rules.
module tb_mmio_led_switch_gpio;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int          DEB  = 4;

  logic        clock = 1'b0;
  logic        reset, mem_read, mem_write, SWITCH_in;
  logic [31:0] addr, wdata, rdata;
  logic        hit, switch_irq;
  logic [3:0]  LEDs_out;

  mmio_led_switch_gpio #(
    .BASE_ADDR       (BASE),
    .DEBOUNCE_CYCLES (DEB),
    .BLINK_DEFAULT   (32'd8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .hit        (hit),
    .SWITCH_in  (SWITCH_in),
    .LEDs_out   (LEDs_out),
    .switch_irq (switch_irq)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: blink phase derived from cycles elapsed since the last
  // period change; switch modelled as a raw-sample delay line plus run length.
  logic [3:0]  m_led, m_mask;
  logic [31:0] m_period;
  logic        m_base;
  int unsigned m_ticks;
  logic        m_d1, m_d2, m_deb, m_sticky;
  int          m_run;

  function automatic logic m_phase();
    if (m_period == 0) return m_base;
    return m_base ^ 1'((m_ticks / m_period) % 2);
  endfunction

  function automatic logic [3:0] m_leds();
    return m_led ^ (m_mask & {4{m_phase()}});
  endfunction

  function automatic logic m_match(input logic [31:0] a);
    return (a & 32'hFFFF_FFF0) == BASE;
  endfunction

  function automatic logic m_hit();
    return m_match(addr) && (mem_read || mem_write);
  endfunction

  function automatic logic [31:0] m_rdata();
    if (!(mem_read && m_match(addr))) return 32'd0;
    case (addr[3:2])
      2'd0:    return {28'd0, m_led};
      2'd1:    return {28'd0, m_mask};
      2'd2:    return {30'd0, m_sticky, m_deb};
      default: return m_period;
    endcase
  endfunction

  task automatic m_edge();
    logic       wr, rise, ph;
    logic [1:0] off;
    if (reset) begin
      m_led = 4'h0; m_mask = 4'h0; m_period = 32'd8; m_base = 1'b0; m_ticks = 0;
      m_d1 = 1'b0; m_d2 = 1'b0; m_deb = 1'b0; m_run = 0; m_sticky = 1'b0;
    end else begin
      wr   = mem_write && m_match(addr);
      off  = addr[3:2];
      rise = 1'b0;
      ph   = m_phase();
      if (m_d2 != m_deb) begin
        m_run++;
        if (m_run == DEB) begin
          m_deb = m_d2;
          m_run = 0;
          rise  = m_deb;
        end
      end else begin
        m_run = 0;
      end
      m_d2 = m_d1;
      m_d1 = SWITCH_in;
      if (rise) m_sticky = 1'b1;
      else if (wr && off == 2'd2 && wdata[1]) m_sticky = 1'b0;
      if (wr && off == 2'd3) begin
        m_base = ph; m_ticks = 0; m_period = wdata;
      end else if (m_period != 0) begin
        m_ticks++;
      end
      if (wr && off == 2'd0) m_led  = wdata[3:0];
      if (wr && off == 2'd1) m_mask = wdata[3:0];
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    m_edge();
    #1;
  endtask

  task automatic idle();
    mem_read = 1'b0; mem_write = 1'b0; addr = 32'd0; wdata = 32'd0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    mem_read = 1'b0; mem_write = 1'b1; addr = a; wdata = d;
    cyc();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1; SWITCH_in = 1'b0; idle();
    cyc(); cyc();
    reset = 1'b0;
    repeat (3) cyc();
    n_cmp++; if (LEDs_out !== 4'h0) begin n_bad++; $display("FAIL reset_leds: got %h want %h", LEDs_out, 4'h0); end
    n_cmp++; if (rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h want %h", rdata, 32'd0); end
    n_cmp++; if (switch_irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", switch_irq); end
    mem_read = 1'b1; addr = BASE + 32'hC; #1;
    n_cmp++; if (rdata !== 32'd8) begin n_bad++; $display("FAIL reset_period: got %h want %h", rdata, 32'd8); end
    n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL reset_hit: got %b want 1", hit); end
    idle();
  endtask

  task automatic test_led_write();
    do_write(BASE, 32'h0000_0005);
    n_cmp++; if (LEDs_out !== 4'h5) begin n_bad++; $display("FAIL led_write: got %h want %h", LEDs_out, 4'h5); end
    mem_read = 1'b1; addr = BASE; #1;
    n_cmp++; if (rdata !== 32'h5) begin n_bad++; $display("FAIL led_read: got %h want %h", rdata, 32'h5); end
    idle();
    mem_write = 1'b1; addr = 32'hFFFE_0000; wdata = 32'hA; #1;
    n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL outside_hit: got %b want 0", hit); end
    cyc(); idle();
    n_cmp++; if (LEDs_out !== 4'h5) begin n_bad++; $display("FAIL outside_write: got %h want %h", LEDs_out, 4'h5); end
  endtask

  task automatic test_blink();
    logic [3:0] v0, v;
    do_write(BASE, 32'h0);
    do_write(BASE + 32'h4, 32'hF);
    do_write(BASE + 32'hC, 32'd3);
    v0 = m_leds();
    for (int i = 0; i < 12; i++) begin
      v = ((i / 3) % 2 == 1) ? ~v0 : v0;
      n_cmp++; if (LEDs_out !== v) begin n_bad++; $display("FAIL blink_c%0d: got %h want %h", i, LEDs_out, v); end
      cyc();
    end
    do_write(BASE + 32'hC, 32'd0);
    v = m_leds();
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_cmp++; if (LEDs_out !== v) begin n_bad++; $display("FAIL blink_frozen_c%0d: got %h want %h", i, LEDs_out, v); end
    end
  endtask

  task automatic test_debounce();
    logic [31:0] exp;
    idle();
    SWITCH_in = 1'b1;
    mem_read = 1'b1; addr = BASE + 32'h8;
    for (int e = 1; e <= 6; e++) begin
      cyc();
      exp = (e == 6) ? 32'h3 : 32'h0;
      n_cmp++; if (rdata !== exp) begin n_bad++; $display("FAIL deb_status_e%0d: got %h want %h", e, rdata, exp); end
      n_cmp++; if (switch_irq !== (e == 6)) begin n_bad++; $display("FAIL deb_irq_e%0d: got %b want %b", e, switch_irq, e == 6); end
    end
    SWITCH_in = 1'b0;
    repeat (8) cyc();
    do_write(BASE + 32'h8, 32'h2);
    SWITCH_in = 1'b1; cyc(); cyc(); SWITCH_in = 1'b0;
    mem_read = 1'b1; addr = BASE + 32'h8;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_cmp++; if (rdata !== 32'h0 || rdata !== m_rdata()) begin n_bad++; $display("FAIL glitch_c%0d: got %h want %h", i, rdata, 32'h0); end
    end
    idle();
  endtask

  task automatic test_sticky();
    SWITCH_in = 1'b1;
    repeat (7) cyc();
    n_cmp++; if (switch_irq !== 1'b1) begin n_bad++; $display("FAIL sticky_set: got %b want 1", switch_irq); end
    do_write(BASE + 32'h8, 32'h2);
    mem_read = 1'b1; addr = BASE + 32'h8; #1;
    n_cmp++; if (rdata !== 32'h1) begin n_bad++; $display("FAIL sticky_clear_rd: got %h want %h", rdata, 32'h1); end
    n_cmp++; if (switch_irq !== 1'b0) begin n_bad++; $display("FAIL sticky_clear_irq: got %b want 0", switch_irq); end
    idle();
    SWITCH_in = 1'b0;
    repeat (8) cyc();
    SWITCH_in = 1'b1;
    repeat (5) cyc();
    mem_write = 1'b1; addr = BASE + 32'h8; wdata = 32'h2;
    cyc(); idle();
    mem_read = 1'b1; addr = BASE + 32'h8; #1;
    n_cmp++; if (rdata !== 32'h3) begin n_bad++; $display("FAIL set_wins_rd: got %h want %h", rdata, 32'h3); end
    n_cmp++; if (switch_irq !== 1'b1) begin n_bad++; $display("FAIL set_wins_irq: got %b want 1", switch_irq); end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp [4];
    exp[0] = 32'd0; exp[1] = 32'd0; exp[2] = 32'd0; exp[3] = 32'd8;
    do_write(BASE, 32'hA);
    do_write(BASE + 32'h4, 32'hF);
    do_write(BASE + 32'hC, 32'd2);
    repeat (3) cyc();
    n_cmp++; if (LEDs_out !== m_leds() || switch_irq !== 1'b1) begin n_bad++; $display("FAIL pre_reset: got %h/%b want %h/1", LEDs_out, switch_irq, m_leds()); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    n_cmp++; if (LEDs_out !== 4'h0) begin n_bad++; $display("FAIL mid_reset_leds: got %h want %h", LEDs_out, 4'h0); end
    n_cmp++; if (switch_irq !== 1'b0) begin n_bad++; $display("FAIL mid_reset_irq: got %b want 0", switch_irq); end
    mem_read = 1'b1;
    for (int r = 0; r < 4; r++) begin
      addr = BASE + 32'(r * 4); #1;
      n_cmp++; if (rdata !== exp[r]) begin n_bad++; $display("FAIL mid_reset_reg%0d: got %h want %h", r, rdata, exp[r]); end
    end
    idle();
    SWITCH_in = 1'b0;
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 5) == 0) SWITCH_in = ~SWITCH_in;
      mem_read  = $urandom_range(0, 1) == 1;
      mem_write = $urandom_range(0, 2) == 0;
      r = int'($urandom_range(0, 9));
      addr = (r < 8) ? (BASE | ($urandom() & 32'hF)) : $urandom();
      wdata = (addr[3:2] == 2'd3) ? 32'($urandom_range(0, 6)) : $urandom();
      #1;
      n_cmp++; if (hit !== m_hit()) begin n_bad++; $display("FAIL rnd_hit_%0d: got %b want %b", i, hit, m_hit()); end
      n_cmp++; if (rdata !== m_rdata()) begin n_bad++; $display("FAIL rnd_rdata_%0d: got %h want %h", i, rdata, m_rdata()); end
      cyc();
      n_cmp++; if (LEDs_out !== m_leds()) begin n_bad++; $display("FAIL rnd_leds_%0d: got %h want %h", i, LEDs_out, m_leds()); end
      n_cmp++; if (switch_irq !== m_sticky) begin n_bad++; $display("FAIL rnd_irq_%0d: got %b want %b", i, switch_irq, m_sticky); end
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_led_write();
    test_blink();
    test_debounce();
    test_sticky();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_led_switch_gpio.md
Name: mmio_led_switch_gpio

Overview:
- Memory-mapped GPIO peripheral directly downstream of the thirtytwo_Mips core's data-memory port.
- Decodes core loads/stores in a fixed 16-byte window.
- Drives the 4 board LEDs (static value plus optional blink) and presents the synchronised, debounced SWITCH_in with a sticky rising-edge flag.
- The core's LEDs_out/SWITCH_in board pins are routed through this block.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, base of register window (bits [3:0] must be 0).
- DEBOUNCE_CYCLES, 4, cycles the synchronised switch must be stable before the debounced level changes (≥1; board build overrides to ~1_000_000).
- BLINK_DEFAULT, 32'd8, reset value of BLINK_PERIOD.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_read  in  1  core load strobe.
- mem_write  in  1  core store strobe.
- addr  in  32  core byte address.
- wdata  in  32  store data.
- rdata  out  32  load data, combinational.
- hit  out  1  addr in window and (mem_read | mem_write).
- SWITCH_in  in  1  raw asynchronous board switch.
- LEDs_out  out  4  board LEDs.
- switch_irq  out  1  sticky rising-edge flag level.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled on the rising edge of clock. Reset mid-operation discards everything and returns all state to its reset values at that edge.
- Address decode:
  - Window match: addr[31:4] == BASE_ADDR[31:4].
  - Register offset: addr[3:2]; addr[1:0] ignored (word access only).
- Register map:
  - 0x0 LED_DATA: RW, bits [3:0]; other bits read 0.
  - 0x4 BLINK_MASK: RW, bits [3:0].
  - 0x8 STATUS: RO bit0 = debounced switch; bit1 = sticky rise flag, write-1-to-clear; all other bits read 0 and ignore writes.
  - 0xC BLINK_PERIOD: RW, 32 bits.
- Reset values: LED_DATA 0, BLINK_MASK 0, BLINK_PERIOD BLINK_DEFAULT, prescaler 0, blink_phase 0, sync flops 0, debounced 0, debounce counter 0, sticky 0. Hence LEDs_out = 0, switch_irq = 0, rdata = 0.
- Read path:
  - rdata is combinational from current register state, valid in the same cycle mem_read && window match.
  - Otherwise rdata = 0.
  - A read and write to the same register in the same cycle returns the pre-write value.
- Write path: a store with window match updates the register on the next rising edge. Stores outside the window are ignored.
- LEDs_out = LED_DATA ^ (BLINK_MASK & {4{blink_phase}}), combinational from registers.
- Blink:
  - If BLINK_PERIOD == 0: prescaler held at 0 and blink_phase frozen.
  - Else: prescaler increments each cycle. When prescaler == BLINK_PERIOD-1, prescaler <= 0 and blink_phase toggles. Phase therefore toggles every BLINK_PERIOD cycles.
  - Any write to BLINK_PERIOD clears the prescaler the same edge; blink_phase is unchanged.
  - Prescaler is 32 bits, compared unsigned; no wrap beyond BLINK_PERIOD-1.
- Switch path:
  - Two-flop synchroniser s1 -> s2.
  - Counter logic:
    - If s2 == debounced, counter <= 0.
    - Else if counter == DEBOUNCE_CYCLES-1, debounced <= s2 and counter <= 0.
    - Else counter++.
  - A stable input change first sampled at edge k appears on debounced after edge k+1+DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at s2 never changes debounced.
- Sticky flag:
  - Set on the edge where debounced goes 0->1.
  - Cleared by a STATUS store with wdata[1] = 1.
  - Simultaneous set and clear: set wins.
  - switch_irq = sticky.
- hit is combinational; it is not asserted when neither strobe is active.

Decomposition:
- Package gpio_pkg:
  - Register offset constants OFF_LED_DATA = 2'd0, OFF_BLINK_MASK = 2'd1, OFF_STATUS = 2'd2, OFF_BLINK_PERIOD = 2'd3.
  - STATUS bit indices ST_LEVEL = 0, ST_RISE = 1.
  - NUM_LEDS = 4.
- Sub-module switch_debouncer (params DEBOUNCE_CYCLES; ports clock, reset, raw_in, level_out, rise_pulse). Holds the synchroniser, counter and edge detect.
- Top module keeps the register file, blink logic and bus decode.

Test Plan:
1. Reset then idle 3 cycles -> LEDs_out = 4'h0, rdata = 0, switch_irq = 0; read 0xFFFF000C returns 32'd8.
2. Store 0xFFFF0000 <= 32'h0000_0005 -> LEDs_out = 4'h5 after the next edge; load 0xFFFF0000 returns 32'h5. A store to 0xFFFE0000 leaves LEDs_out = 4'h5 and hit = 0.
3. LED_DATA = 4'h0, BLINK_MASK = 4'hF, BLINK_PERIOD = 3 -> LEDs_out toggles 0x0/0xF every 3 cycles. Writing BLINK_PERIOD = 0 freezes the current value for ≥10 cycles.
4. SWITCH_in held 1 with DEBOUNCE_CYCLES = 4 -> STATUS bit0 = 1 exactly 6 edges after first sampling; bit1 = 1 and switch_irq = 1 on that edge. A 2-cycle pulse on SWITCH_in produces no change.
5. Sticky set: store STATUS <= 32'h2 -> bit1 = 0 and switch_irq = 0 next cycle. A store of 32'h2 on the same edge as a new rising debounce leaves bit1 = 1.
6. Reset asserted mid-blink with LED_DATA = 4'hA and sticky set -> on the next edge all registers return to reset values and LEDs_out = 0.
